// File: rtl/alu_result_serializer.sv
// Serializes WIDTH-bit ALU results into bytes on a valid/ready interface toward UART TX.
// One pending word is buffered during a transfer; any further overflow is dropped and flagged.
module alu_result_serializer #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             ser_busy,
    output logic             drop_flag
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;

    logic accept;
    logic last;

    assign accept = tx_valid_q && tx_ready;
    assign last   = (cnt_q == CW'(NBYTES - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        drop_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (alu_valid) begin
                    shift_d = alu_out;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept && !last) begin
                    shift_d = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
                    cnt_d   = cnt_q + CW'(1);
                end else if (accept) begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        shift_d      = pend_q;
                        pend_valid_d = 1'b0;
                    end else if (alu_valid) begin
                        shift_d = alu_out;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // Checking pend_valid_d lets a final accept free the buffer for this cycle's word.
                if (alu_valid && !(accept && last && !pend_valid_q)) begin
                    if (!pend_valid_d) begin
                        pend_d       = alu_out;
                        pend_valid_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        tx_data_d  = MSB_FIRST ? shift_d[WIDTH-1 -: 8] : shift_d[7:0];
        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d == SEND) || pend_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign ser_busy  = busy_q;
    assign drop_flag = drop_q;
endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed scenarios plus random traffic against a byte-queue model.
module tb_alu_result_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid, ser_busy, drop_flag;

    logic [31:0] alu_out32 = '0;
    logic        alu_valid32 = 1'b0;
    logic        tx_ready32 = 1'b1;
    logic [7:0]  tx_data32;
    logic        tx_valid32, ser_busy32, drop_flag32;

    int checks = 0;
    int failures = 0;

    // Model: bytes still to send of the current word, plus a one-word pending slot.
    logic [7:0]  cur_q[$];
    logic [15:0] pend_w;
    bit          pend_v;
    bit          exp_drop;

    always #5 clk = ~clk;

    alu_result_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) u_dut (
        .clk(clk), .rst(rst), .alu_out(alu_out), .alu_valid(alu_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .ser_busy(ser_busy), .drop_flag(drop_flag)
    );

    alu_result_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_dut32 (
        .clk(clk), .rst(rst), .alu_out(alu_out32), .alu_valid(alu_valid32), .tx_ready(tx_ready32),
        .tx_data(tx_data32), .tx_valid(tx_valid32), .ser_busy(ser_busy32), .drop_flag(drop_flag32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] w);
        cur_q.delete();
        cur_q.push_back(w[7:0]);
        cur_q.push_back(w[15:8]);
    endtask

    // One clock: drive inputs, advance the model, compare outputs 1 time unit after the edge.
    task automatic step(input bit r, input bit av, input logic [15:0] aw, input bit rdy);
        rst = r; alu_valid = av; alu_out = aw; tx_ready = rdy;
        @(posedge clk);
        exp_drop = 1'b0;
        if (r) begin
            cur_q.delete();
            pend_v = 1'b0;
        end else begin
            if (cur_q.size() > 0 && rdy) void'(cur_q.pop_front());
            if (cur_q.size() == 0 && pend_v) begin
                load_word(pend_w);
                pend_v = 1'b0;
            end
            if (av) begin
                if (cur_q.size() == 0) load_word(aw);
                else if (!pend_v) begin pend_w = aw; pend_v = 1'b1; end
                else exp_drop = 1'b1;
            end
        end
        #1;
        rst = 1'b0; alu_valid = 1'b0;
        chk("tx_valid", 32'(tx_valid), 32'(cur_q.size() > 0));
        chk("ser_busy", 32'(ser_busy), 32'(cur_q.size() > 0 || pend_v));
        chk("drop_flag", 32'(drop_flag), 32'(exp_drop));
        if (cur_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(cur_q[0]));
        if (r) chk("reset_tx_data", 32'(tx_data), 32'h0);
    endtask

    initial begin
        logic [7:0] exp32 [4];
        pend_v = 1'b0;
        pend_w = '0;
        #2;
        // Reset and basic A55A word, LSB first with 1-cycle latency.
        step(1, 0, '0, 1);
        step(0, 1, 16'hA55A, 1);
        chk("first_byte", 32'(tx_data), 32'h5A);
        step(0, 0, '0, 1);
        chk("second_byte", 32'(tx_data), 32'hA5);
        step(0, 0, '0, 1);
        chk("idle_after_word", 32'({tx_valid, ser_busy}), 32'h0);

        // 32-bit MSB-first instance.
        exp32[0] = 8'h11; exp32[1] = 8'h22; exp32[2] = 8'h33; exp32[3] = 8'h44;
        alu_out32 = 32'h11223344; alu_valid32 = 1'b1;
        @(posedge clk); #1;
        alu_valid32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("msb32_valid", 32'(tx_valid32), 32'h1);
            chk("msb32_byte", 32'(tx_data32), 32'(exp32[i]));
            @(posedge clk); #1;
        end
        chk("msb32_idle", 32'({tx_valid32, ser_busy32}), 32'h0);

        // Backpressure: first byte held stable for 5 cycles.
        step(0, 1, 16'hA55A, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 0);
            chk("hold_byte", 32'({tx_valid, tx_data}), 32'h15A);
        end
        step(0, 0, '0, 1);
        chk("after_hold", 32'(tx_data), 32'hA5);
        step(0, 0, '0, 1);

        // Pending plus overflow drop; words stream back-to-back.
        step(0, 1, 16'h1234, 0);
        step(0, 1, 16'hBEEF, 0);
        step(0, 1, 16'hCAFE, 0);
        chk("drop_pulse", 32'(drop_flag), 32'h1);
        step(0, 0, '0, 0);
        chk("drop_one_cycle", 32'(drop_flag), 32'h0);
        step(0, 0, '0, 1);
        chk("stream_12", 32'({tx_valid, tx_data}), 32'h112);
        step(0, 0, '0, 1);
        chk("stream_EF", 32'({tx_valid, tx_data}), 32'h1EF);
        step(0, 0, '0, 1);
        chk("stream_BE", 32'({tx_valid, tx_data}), 32'h1BE);
        step(0, 0, '0, 1);

        // Bypass: new word arrives on the final-byte accept with pending empty.
        step(0, 1, 16'h1111, 1);
        step(0, 0, '0, 1);
        step(0, 1, 16'h0F0F, 1);
        chk("bypass", 32'({tx_valid, drop_flag, tx_data}), 32'h20F);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // Reset with second byte waiting and a word pending.
        step(0, 1, 16'h1234, 0);
        step(0, 1, 16'h5678, 1);
        step(0, 0, '0, 0);
        step(1, 0, '0, 0);
        chk("reset_mid", 32'({tx_valid, ser_busy, drop_flag}), 32'h0);
        step(0, 1, 16'h9ABC, 1);
        chk("post_reset_lo", 32'(tx_data), 32'hBC);
        step(0, 0, '0, 1);
        chk("post_reset_hi", 32'(tx_data), 32'h9A);
        step(0, 0, '0, 1);
        chk("post_reset_idle", 32'({tx_valid, ser_busy}), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 150) == 0, ($urandom % 3) == 0, 16'($urandom), ($urandom % 4) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
Drains ALU results toward the UART transmit path. It captures a WIDTH-bit ALU result on its one-cycle valid flag and emits it as WIDTH/8 bytes on a valid/ready byte interface. It sits between the ALU output stage and the UART TX byte input. A one-deep pending buffer absorbs a result that arrives while a transfer is in progress; further overflow is flagged and discarded.

Parameters:
WIDTH, 16, ALU result width; must be a multiple of 8 and at least 8 (NBYTES = WIDTH/8).
MSB_FIRST, 0, 0 = least-significant byte sent first, 1 = most-significant byte sent first.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
alu_out  in  WIDTH  ALU result word.
alu_valid  in  1  one-cycle pulse, alu_out valid this cycle.
tx_ready  in  1  UART TX can accept a byte this cycle.
tx_data  out  8  byte presented to UART TX.
tx_valid  out  1  tx_data valid; transfer occurs when tx_valid && tx_ready.
ser_busy  out  1  high while a word is being sent or a word is pending.
drop_flag  out  1  one-cycle pulse when an incoming result is discarded.

Behaviour:
- Reset: rst sampled high at a rising edge clears all outputs and state at that edge.
  - tx_data = 0, tx_valid = 0, ser_busy = 0, drop_flag = 0.
  - FSM goes to IDLE; byte counter = 0; shift register and pending buffer cleared; pending_valid = 0.
  - Reset mid-transfer aborts the word in flight and any pending word. Nothing is resumed.
- Registers: all outputs are registered; there is no combinational path from any input to any output.
- FSM states: IDLE, SEND.
- IDLE:
  - tx_valid = 0.
  - alu_valid = 1: capture alu_out into the shift register, clear the byte counter, go to SEND.
  - tx_valid = 1 with the first byte on the next cycle. Latency is 1 cycle from alu_valid to tx_valid.
- SEND:
  - tx_valid = 1. tx_data holds the current byte and stays stable until accepted.
  - Byte order: MSB_FIRST = 0 sends bits [7:0] first; MSB_FIRST = 1 sends bits [WIDTH-1:WIDTH-8] first.
- Accept of a non-final byte (counter < NBYTES-1): advance to the next byte and increment the counter. The next byte appears the following cycle and tx_valid stays 1 (no bubble).
- Accept of the final byte (counter = NBYTES-1):
  - pending_valid = 1: load the pending word into the shift register, clear pending_valid, counter = 0, stay in SEND. tx_valid stays 1.
  - pending_valid = 0 and alu_valid = 1 this cycle: load alu_out directly into the shift register and stay in SEND.
  - Otherwise: go to IDLE, tx_valid = 0 next cycle.
- alu_valid in SEND, other than the bypass case above:
  - pending_valid = 0: store alu_out in the pending buffer and set pending_valid.
  - pending_valid = 1 and no final accept this cycle: discard alu_out and pulse drop_flag for exactly 1 cycle.
  - pending_valid = 1 and final accept this cycle: the pending word moves to the shift register and alu_out enters the pending buffer. No drop.
- tx_ready low: all state holds; tx_data and tx_valid are unchanged. There is no timeout.
- ser_busy = (state == SEND) or pending_valid, registered with the state.
- drop_flag is 0 on every cycle except a discard cycle.

Test Plan:
- Reset, tx_ready = 1, alu_out = 16'hA55A pulsed once → tx_valid rises 1 cycle later; bytes 8'h5A then 8'hA5 on consecutive cycles; then tx_valid = 0 and ser_busy = 0.
- MSB_FIRST = 1, WIDTH = 32, alu_out = 32'h11223344 → bytes 11, 22, 33, 44 in order.
- tx_ready held low 5 cycles after the first byte → tx_data = 8'h5A stable and tx_valid = 1 throughout; the second byte appears only after tx_ready returns.
- 1234 sent with tx_ready low; pulse BEEF, then CAFE → CAFE dropped: drop_flag high exactly 1 cycle. Output stream is 34, 12, EF, BE with no bubble between words.
- alu_valid with 0x0F0F on the same cycle as the final-byte accept, pending empty → 0x0F0F bytes follow immediately; tx_valid never deasserts; drop_flag stays 0.
- rst asserted while the second byte is waiting, with a word pending → at the next edge tx_valid = 0, ser_busy = 0, pending cleared. A new alu_valid after reset sends only the new word.
